// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter that shares the single register-file
// write port (WE3/A3/WD3) between the ALU writeback (req0) and the load
// writeback (req1). The write-port outputs are registered. Writes to x0
// complete their handshake but never raise WE3.
//
// Optional build macro RF_WR_STATS_EN adds two saturating 16-bit counters:
// conflict_cnt counts cycles where both requesters are valid, and drop_cnt
// counts accepted writes to x0.
//
// Handshake: reqN_valid is driven by the requester, and reqN_ready is driven
// combinationally by this block. A transfer happens at a rising edge where
// valid && ready. Once a requester raises valid, it holds valid, addr and data
// stable until it sees ready. At most one ready is high in any cycle, and both
// readys are low while rst is high.
module rf_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              last_grant
`ifdef RF_WR_STATS_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    // Round-robin pointer. 0 favours req0 and 1 favours req1 when both are valid.
    logic              ptr;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grant decision: a lone valid always wins, and under contention the pointer decides.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~ptr;
                grant1 = ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign sel_addr   = grant1 ? req1_addr : req0_addr;
    assign sel_data   = grant1 ? req1_data : req0_data;

    // Write-port registers and pointer. An accept loads addr/data, a non-accept only drops WE3.
    always_ff @(posedge clk) begin
        if (rst) begin
            WE3        <= 1'b0;
            A3         <= '0;
            WD3        <= '0;
            last_grant <= 1'b0;
            ptr        <= 1'b0;
        end else if (accept) begin
            WE3        <= (sel_addr != '0);
            A3         <= sel_addr;
            WD3        <= sel_data;
            last_grant <= grant1;
            ptr        <= ~grant1;
        end else begin
            WE3        <= 1'b0;
        end
    end

`ifdef RF_WR_STATS_EN
    // Saturating statistics counters; both are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            if (req0_valid && req1_valid && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
            if (accept && (sel_addr == '0) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios followed by random traffic. A
// behavioural model tracks the grant rules and the expected write port. A
// negedge compare process checks the DUT against this model on every cycle.
// A small register-file array is fed from the DUT write port so that
// read-back values can be checked.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        v0;
    logic        v1;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        req0_ready;
    logic        req1_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        last_grant;
`ifdef RF_WR_STATS_EN
    logic [15:0] conflict_cnt;
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    rf_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_addr(a0), .req0_data(d0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_addr(a1), .req1_data(d1),
        .WE3(WE3), .A3(A3), .WD3(WD3), .last_grant(last_grant)
`ifdef RF_WR_STATS_EN
        , .conflict_cnt(conflict_cnt), .drop_cnt(drop_cnt)
`endif
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grant rule: a lone valid wins, both valid -> the favoured one, none -> -1.
    function automatic int pick(input logic q0, input logic q1, input logic fav);
        if (q0 && q1) return fav ? 1 : 0;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    // Behavioural model state.
    logic        model_on = 1'b0;
    logic        m_ptr, m_we, m_lg;
    logic [4:0]  m_a;
    logic [31:0] m_wd;
    int          m_conf, m_drop;
    logic [31:0] mrf [32];
    logic [31:0] drf [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            mrf[i] = '0;
            drf[i] = '0;
        end
    end

    // Register file fed by the DUT write port; it commits on the edge after WE3 rises.
    always @(posedge clk) if (WE3) drf[A3] <= WD3;

    // Model update: applies the spec rules to the inputs seen at each edge.
    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_ptr = 0; m_we = 0; m_a = 0; m_wd = 0; m_lg = 0;
            m_conf = 0; m_drop = 0;
            model_on = 1'b1;
        end else begin
            g = pick(v0, v1, m_ptr);
            if (v0 && v1 && m_conf < 65535) m_conf++;
            if (g >= 0) begin
                m_a  = (g == 1) ? a1 : a0;
                m_wd = (g == 1) ? d1 : d0;
                m_we = (m_a != 0);
                m_lg = (g == 1);
                m_ptr = (g == 0);
                if (m_a == 0) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mrf[m_a] = m_wd;
                end
            end else begin
                m_we = 0;
            end
        end
    end

    // Compare process: checks every DUT output against the model at each negedge.
    always @(negedge clk) begin
        int g;
        if (model_on) begin
            g = rst ? -1 : pick(v0, v1, m_ptr);
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
            chk("one_hot_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            chk("WE3", {31'd0, WE3}, {31'd0, m_we});
            chk("A3", {27'd0, A3}, {27'd0, m_a});
            chk("WD3", WD3, m_wd);
            chk("last_grant", {31'd0, last_grant}, {31'd0, m_lg});
`ifdef RF_WR_STATS_EN
            chk("conflict_cnt", {16'd0, conflict_cnt}, 32'(m_conf));
            chk("drop_cnt", {16'd0, drop_cnt}, 32'(m_drop));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg_ready(input string nm, input logic e0, input logic e1);
        @(negedge clk);
        chk({nm, "_r0"}, {31'd0, req0_ready}, {31'd0, e0});
        chk({nm, "_r1"}, {31'd0, req1_ready}, {31'd0, e1});
    endtask

    // Directed scenarios followed by random traffic, then the summary line.
    initial begin
        logic acc0, acc1;
        int   i0, i1;
        rst = 1; v0 = 1; a0 = 5; d0 = 32'h55; v1 = 1; a1 = 3; d1 = 32'h33;
        acc0 = 0; acc1 = 0;

        // Reset held with both valids high.
        tick(); tick();
        neg_ready("reset", 0, 0);
        chk("reset_WE3", {31'd0, WE3}, 0);
        chk("reset_A3", {27'd0, A3}, 0);
        chk("reset_WD3", WD3, 0);
        tick();
        rst = 0;
        neg_ready("release", 1, 0);
        tick();
        chk("release_A3", {27'd0, A3}, 5);
        chk("release_lg", {31'd0, last_grant}, 0);
        v0 = 0;
        neg_ready("release2", 0, 1);
        tick();
        chk("release2_A3", {27'd0, A3}, 3);
        v1 = 0;
        tick();
        chk("idle_WE3", {31'd0, WE3}, 0);
        chk("idle_A3_hold", {27'd0, A3}, 3);

        // Single requester req0: addr 5, data 0xE9.
        v0 = 1; a0 = 5; d0 = 32'h000000E9;
        neg_ready("single0", 1, 0);
        tick();
        chk("single0_WE3", {31'd0, WE3}, 1);
        chk("single0_A3", {27'd0, A3}, 5);
        chk("single0_WD3", WD3, 32'hE9);
        v0 = 0;
        tick();
        chk("rf5", drf[5], 233);

        // Single requester req1 (moves the pointer back to 0).
        v1 = 1; a1 = 2; d1 = 32'h22;
        neg_ready("single1", 0, 1);
        tick();
        chk("single1_A3", {27'd0, A3}, 2);
        v1 = 0;

        // Continuous contention: grants must alternate 0,1,0,1,0,1.
        i0 = 0; i1 = 0; v0 = 1; v1 = 1;
        for (int k = 0; k < 6; k++) begin
            a0 = 5'(1 + i0); d0 = 32'(256 + i0);
            a1 = 5'(4 + i1); d1 = 32'(512 + i1);
            neg_ready("contend", (k % 2) == 0, (k % 2) == 1);
            tick();
            chk("contend_lg", {31'd0, last_grant}, 32'(k % 2));
            chk("contend_A3", {27'd0, A3}, (k % 2) ? 32'(4 + i1) : 32'(1 + i0));
            if (k % 2) i1++; else i0++;
        end
        v0 = 0; v1 = 0;

        // x0 write from req1 is accepted but dropped.
        v1 = 1; a1 = 0; d1 = 32'hDEADBEEF;
        neg_ready("x0", 0, 1);
        tick();
        chk("x0_WE3", {31'd0, WE3}, 0);
        chk("x0_WD3", WD3, 32'hDEADBEEF);
`ifdef RF_WR_STATS_EN
        chk("x0_drop_cnt", {16'd0, drop_cnt}, 1);
`endif
        v1 = 0;
        tick();
        chk("rf0", drf[0], 0);

        // Same address from both requesters: 10 then 20, and 20 survives.
        v0 = 1; a0 = 7; d0 = 10; v1 = 1; a1 = 7; d1 = 20;
        neg_ready("same_a", 1, 0);
        tick();
        chk("same_a_WD3", WD3, 10);
        v0 = 0;
        neg_ready("same_b", 0, 1);
        tick();
        chk("same_b_WD3", WD3, 20);
        v1 = 0;
        tick();
        chk("rf7", drf[7], 20);

        // Mid-operation reset while req1 targets register 9 (pointer first set to 1).
        v0 = 1; a0 = 8; d0 = 32'h88;
        tick();
        v0 = 1; a0 = 10; d0 = 32'hAA; v1 = 1; a1 = 9; d1 = 32'h99; rst = 1;
        neg_ready("midrst", 0, 0);
        tick();
        chk("midrst_WE3", {31'd0, WE3}, 0);
        chk("midrst_lg", {31'd0, last_grant}, 0);
`ifdef RF_WR_STATS_EN
        chk("midrst_conflict", {16'd0, conflict_cnt}, 0);
`endif
        rst = 0;
        neg_ready("midrst_ptr", 1, 0);
        tick();
        v0 = 0; v1 = 0;
        tick();
        chk("rf9", drf[9], 0);

        // Random traffic: requesters hold their request until it is accepted.
        for (int n = 0; n < 3000; n++) begin
            if (rst) begin
                v0 = 0; v1 = 0;
            end else begin
                if (acc0) v0 = 0;
                if (acc1) v1 = 0;
            end
            if (!v0 && $urandom_range(0, 3) != 0) begin
                v0 = 1;
                a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                d0 = $urandom;
            end
            if (!v1 && $urandom_range(0, 3) != 0) begin
                v1 = 1;
                a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                d1 = $urandom;
            end
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            acc0 = req0_ready;
            acc1 = req1_ready;
            tick();
        end
        rst = 0; v0 = 0; v1 = 0;
        tick(); tick();
        for (int r = 0; r < 32; r++) chk("rf_final", drf[r], mrf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
